// File: rtl/toggle_pkg.sv
// -----------------------------------------------------------------------------
// toggle_pkg
// Shared definitions for the toggle request generator:
//   - two-bit state encodings and the FSM state enum built on them
//   - default debounce length and press-counter width
//   - helper that sizes the debounce counter from the debounce length
// -----------------------------------------------------------------------------
package toggle_pkg;

    // State encodings, kept as named constants so other blocks (status
    // decoders, debug taps) can refer to the raw values.
    localparam logic [1:0] IDLE        = 2'd0;
    localparam logic [1:0] DEB_PRESS   = 2'd1;
    localparam logic [1:0] HELD        = 2'd2;
    localparam logic [1:0] DEB_RELEASE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE        = IDLE,
        ST_DEB_PRESS   = DEB_PRESS,
        ST_HELD        = HELD,
        ST_DEB_RELEASE = DEB_RELEASE
    } state_e;

    // Default number of consecutive stable synchronised cycles needed to
    // accept a press or a release.
    localparam int DEBOUNCE_CYCLES_DEF = 4;

    // Default width of the accepted-press counter.
    localparam int CNT_W_DEF = 8;

    // Debounce counter width: must be able to hold DEBOUNCE_CYCLES itself,
    // which is the saturation value.
    function automatic int deb_cnt_w(input int cycles);
        deb_cnt_w = $clog2(cycles + 1);
    endfunction

endpackage : toggle_pkg

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// One-bit two-flop synchroniser for a level that is asynchronous to clk.
// The output is the input delayed by two rising clock edges. Both flops
// clear to 0 on the asynchronous active-low reset.
//
// Ports:
//   clk    in   1  destination clock, rising edge
//   rst_n  in   1  asynchronous active-low reset
//   d      in   1  asynchronous input level
//   q      out  1  synchronised level
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture; meta_r may go metastable, sync_r gives it a full
    // cycle to resolve before anything downstream looks at it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule : sync_2ff

// File: rtl/toggle_req_gen.sv
// -----------------------------------------------------------------------------
// toggle_req_gen
// Upstream request stage for a toggle flip-flop. A raw, bouncy push-button
// level is synchronised and debounced; every accepted press produces one
// single-cycle pulse on t_out (wired straight to the flip-flop's t input)
// and bumps a wrapping press counter.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable synchronised cycles to accept a
//                    press or release (1..65535)
//   CNT_W            width of press_cnt
//
// Ports:
//   clk        in   1      system clock, rising edge
//   rst        in   1      asynchronous active-low reset
//   btn_in     in   1      raw push-button level, asynchronous, may bounce
//   en         in   1      press-accept enable, synchronous to clk
//   t_out      out  1      single-cycle toggle pulse
//   press_cnt  out  CNT_W  accepted presses, wraps modulo 2^CNT_W
//   busy       out  1      FSM is not idle
// -----------------------------------------------------------------------------
module toggle_req_gen
    import toggle_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_in,
    input  logic             en,
    output logic             t_out,
    output logic [CNT_W-1:0] press_cnt,
    output logic             busy
);

    localparam int DCW = deb_cnt_w(DEBOUNCE_CYCLES);

    // Terminal count: the accepting/returning edge is the one seen while the
    // counter already holds DEBOUNCE_CYCLES-1.
    localparam logic [DCW-1:0]   CNT_LAST  = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DCW-1:0]   CNT_SAT   = DCW'(DEBOUNCE_CYCLES);
    localparam logic [DCW-1:0]   CNT_ZERO  = DCW'(1'b0);
    localparam logic [DCW-1:0]   CNT_ONE   = DCW'(1'b1);
    localparam logic [CNT_W-1:0] PRESS_ONE = CNT_W'(1'b1);

    logic             btn_s;
    state_e           state_r;
    state_e           state_s;
    logic [DCW-1:0]   deb_cnt_r;
    logic [DCW-1:0]   deb_cnt_s;
    logic             t_out_r;
    logic             t_out_s;
    logic [CNT_W-1:0] press_cnt_r;
    logic [CNT_W-1:0] press_cnt_s;

    // Saturating increment: the debounce counter must never wrap back into
    // a value that could look like a fresh count.
    function automatic logic [DCW-1:0] sat_inc(input logic [DCW-1:0] v);
        if (v == CNT_SAT) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_ONE;
        end
    endfunction

    // Bring the asynchronous button level into the clk domain.
    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst),
        .d     (btn_in),
        .q     (btn_s)
    );

    // Next-state, debounce counter, pulse and press-count decode.
    // t_out_s defaults low so a pulse can never last more than one cycle.
    always_comb begin
        state_s     = state_r;
        deb_cnt_s   = deb_cnt_r;
        t_out_s     = 1'b0;
        press_cnt_s = press_cnt_r;

        case (state_r)
            ST_IDLE: begin
                if (btn_s) begin
                    state_s   = ST_DEB_PRESS;
                    deb_cnt_s = CNT_ZERO;
                end else begin
                    state_s   = ST_IDLE;
                end
            end

            ST_DEB_PRESS: begin
                if (!btn_s) begin
                    // Too short to be a press: drop it silently.
                    state_s   = ST_IDLE;
                    deb_cnt_s = CNT_ZERO;
                end else if (deb_cnt_r == CNT_LAST) begin
                    // Press accepted. en only matters on this edge; with en
                    // low the press is swallowed but still tracked as held.
                    state_s   = ST_HELD;
                    deb_cnt_s = CNT_ZERO;
                    if (en) begin
                        t_out_s     = 1'b1;
                        press_cnt_s = press_cnt_r + PRESS_ONE;
                    end else begin
                        t_out_s     = 1'b0;
                        press_cnt_s = press_cnt_r;
                    end
                end else begin
                    deb_cnt_s = sat_inc(deb_cnt_r);
                end
            end

            ST_HELD: begin
                if (!btn_s) begin
                    state_s   = ST_DEB_RELEASE;
                    deb_cnt_s = CNT_ZERO;
                end else begin
                    state_s   = ST_HELD;
                end
            end

            ST_DEB_RELEASE: begin
                if (btn_s) begin
                    // Release bounce: still held, and no new pulse.
                    state_s   = ST_HELD;
                    deb_cnt_s = CNT_ZERO;
                end else if (deb_cnt_r == CNT_LAST) begin
                    state_s   = ST_IDLE;
                    deb_cnt_s = CNT_ZERO;
                end else begin
                    deb_cnt_s = sat_inc(deb_cnt_r);
                end
            end

            default: begin
                state_s   = ST_IDLE;
                deb_cnt_s = CNT_ZERO;
            end
        endcase
    end

    // State, counter and output registers; reset clears everything at once,
    // so a press being debounced when reset hits is simply lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            deb_cnt_r   <= CNT_ZERO;
            t_out_r     <= 1'b0;
            press_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_s;
            deb_cnt_r   <= deb_cnt_s;
            t_out_r     <= t_out_s;
            press_cnt_r <= press_cnt_s;
        end
    end

    assign t_out     = t_out_r;
    assign press_cnt = press_cnt_r;
    assign busy      = (state_r != ST_IDLE);

endmodule : toggle_req_gen

// File: tb/tb_toggle_req_gen.sv
module tb_toggle_req_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_in;
    logic       en;
    logic       t0, t1, b0, b1;
    logic [7:0] c0;
    logic [1:0] c1;
    logic       q0;

    always #5 clk = ~clk;

    toggle_req_gen #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .btn_in(btn_in), .en(en),
        .t_out(t0), .press_cnt(c0), .busy(b0)
    );

    toggle_req_gen #(.DEBOUNCE_CYCLES(1), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .btn_in(btn_in), .en(en),
        .t_out(t1), .press_cnt(c1), .busy(b1)
    );

    // Downstream toggle flip-flop driven by t_out of dut0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q0 <= 1'b0;
        else if (t0) q0 <= ~q0;
    end

    int checks   = 0;
    int failures = 0;

    // Reference model: the synchronised level is the raw level two edges
    // late; a change of the debounced level is accepted once the
    // synchronised level has differed from it on DEBOUNCE_CYCLES+1
    // consecutive edges. Each accepted rise with en high is one pulse.
    int m_s1[2], m_s2[2], m_lvl[2], m_run[2], m_cnt[2], m_t[2];
    int m_dc[2];
    int m_mask[2];

    typedef struct {
        logic btn;
        logic en;
        int   cycles;
        int   exp_pulses;
        int   exp_cnt;
        logic exp_busy;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_s1[k] = 0; m_s2[k] = 0; m_lvl[k] = 0;
            m_run[k] = 0; m_cnt[k] = 0; m_t[k] = 0;
        end
    endtask

    task automatic model_edge();
        int bs;
        if (rst == 1'b0) begin
            model_reset();
        end else begin
            for (int k = 0; k < 2; k++) begin
                bs       = m_s2[k];
                m_s2[k]  = m_s1[k];
                m_s1[k]  = int'(btn_in);
                m_t[k]   = 0;
                if (bs != m_lvl[k]) begin
                    m_run[k]++;
                    if (m_run[k] == m_dc[k] + 1) begin
                        m_lvl[k] = bs;
                        m_run[k] = 0;
                        if (bs == 1 && en == 1'b1) begin
                            m_t[k]   = 1;
                            m_cnt[k] = (m_cnt[k] + 1) & m_mask[k];
                        end
                    end
                end else begin
                    m_run[k] = 0;
                end
            end
        end
    endtask

    task automatic model_cmp();
        chk("m0_t_out", int'(t0), m_t[0]);
        chk("m0_busy", int'(b0), int'(m_lvl[0] != 0 || m_run[0] != 0));
        chk("m0_press_cnt", int'(c0), m_cnt[0]);
        chk("m1_t_out", int'(t1), m_t[1]);
        chk("m1_busy", int'(b1), int'(m_lvl[1] != 0 || m_run[1] != 0));
        chk("m1_press_cnt", int'(c1), m_cnt[1]);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        model_cmp();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int first;
        int pulses;
        int qchg;
        logic prev_t;
        logic prev_q;
        int lvl;
        int len;

        m_dc[0] = 4;   m_dc[1] = 1;
        m_mask[0] = 255; m_mask[1] = 3;
        model_reset();

        tbl[0]  = '{1'b0, 1'b1,  5, 0, 0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 20, 1, 1, 1'b1};
        tbl[2]  = '{1'b0, 1'b1, 20, 0, 1, 1'b0};
        tbl[3]  = '{1'b1, 1'b1,  3, 0, 1, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 10, 0, 1, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 20, 0, 1, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 20, 0, 1, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 20, 1, 2, 1'b1};
        tbl[8]  = '{1'b0, 1'b1,  2, 0, 2, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 10, 0, 2, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 20, 0, 2, 1'b0};

        // Reset held with the button pressed: outputs stay cleared.
        rst = 1'b0; btn_in = 1'b1; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_t_out", int'(t0), 0);
            chk("rst_press_cnt", int'(c0), 0);
            chk("rst_busy", int'(b0), 0);
        end

        // Release reset with the button still held: pulse on the 7th edge.
        rst = 1'b1;
        first = 0;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (t0 && first == 0) first = n;
        end
        chk("latency_edges_dc4", first, 7);
        chk("latency_cnt", int'(c0), 1);
        btn_in = 1'b0;
        steps(20);

        // Reset while debouncing (DEB_PRESS, count 2) clears asynchronously.
        btn_in = 1'b1;
        steps(5);
        chk("mid_deb_busy", int'(b0), 1);
        #2 rst = 1'b0;
        #1;
        chk("async_t_out", int'(t0), 0);
        chk("async_busy", int'(b0), 0);
        chk("async_press_cnt", int'(c0), 0);
        model_reset();
        steps(2);
        rst = 1'b1; btn_in = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (t0) pulses++;
        end
        chk("post_rst_no_pulse", pulses, 0);

        // Table-driven phases for the default-parameter instance.
        prev_t = 1'b0;
        for (int r = 0; r < 11; r++) begin
            btn_in = tbl[r].btn;
            en     = tbl[r].en;
            pulses = 0;
            for (int i = 0; i < tbl[r].cycles; i++) begin
                step();
                if (t0) pulses++;
                chk("no_back_to_back", int'(t0 & prev_t), 0);
                prev_t = t0;
            end
            chk($sformatf("row%0d_pulses", r), pulses, tbl[r].exp_pulses);
            chk($sformatf("row%0d_press_cnt", r), int'(c0), tbl[r].exp_cnt);
            chk($sformatf("row%0d_busy", r), int'(b0), int'(tbl[r].exp_busy));
        end

        // End-to-end with the downstream flip-flop, plus CNT_W=2 wrap.
        rst = 1'b0; btn_in = 1'b0; en = 1'b1;
        steps(2);
        rst = 1'b1;
        steps(3);
        qchg = 0;
        prev_q = q0;
        for (int p = 1; p <= 5; p++) begin
            btn_in = 1'b1;
            for (int i = 0; i < 12; i++) begin
                step();
                if (q0 != prev_q) qchg++;
                prev_q = q0;
            end
            btn_in = 1'b0;
            for (int i = 0; i < 12; i++) begin
                step();
                if (q0 != prev_q) qchg++;
                prev_q = q0;
            end
            if (p == 4) chk("wrap_cnt_w2", int'(c1), 0);
        end
        chk("ff_q_final", int'(q0), 1);
        chk("ff_toggles", qchg, 5);
        chk("e2e_press_cnt", int'(c0), 5);
        chk("e2e_press_cnt_w2", int'(c1), 1);

        // Randomised bouncing stimulus against the model.
        for (int s = 0; s < 600; s++) begin
            lvl    = $urandom_range(0, 1);
            len    = $urandom_range(1, 10);
            btn_in = lvl[0];
            en     = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 80) == 0) begin
                rst = 1'b0;
                step();
                rst = 1'b1;
            end
            steps(len);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_toggle_req_gen

// File: doc/toggle_req_gen.md
Name: toggle_req_gen

Overview:
- Upstream request stage for the toggle flip-flop.
- Takes a raw, asynchronous, bouncy push-button input and synchronises and debounces it.
- Emits exactly one single-cycle toggle pulse per accepted press; t_out drives the flip-flop's t input directly.
- Also keeps a wrapping count of accepted presses for status/debug.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive synchronised-stable cycles required to accept a press or release; legal range 1..65535.
- CNT_W, 8, width of the press_cnt counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset. rst=0 resets immediately; release is clean (synchronous to clk).
- btn_in  input  1  raw push-button level, asynchronous to clk, may bounce.
- en  input  1  press-accept enable, synchronous to clk.
- t_out  output  1  single-cycle toggle pulse to the downstream flip-flop.
- press_cnt  output  CNT_W  number of accepted presses, wraps modulo 2^CNT_W.
- busy  output  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - t_out=0, press_cnt=0, busy=0.
  - State IDLE, debounce counter 0, both synchroniser flops 0.
  - Reset asserted mid-debounce aborts with no pulse.
- Synchroniser: two flops. btn_s is btn_in delayed by 2 edges; all FSM decisions use btn_s only.
- Debounce counter: width $clog2(DEBOUNCE_CYCLES+1). It is cleared on every state entry and saturates, never wraps.
- FSM states: IDLE, DEB_PRESS, HELD, DEB_RELEASE.
- IDLE:
  - btn_s=1 -> DEB_PRESS, cnt=0.
  - otherwise stay.
- DEB_PRESS:
  - btn_s=0 -> IDLE (glitch rejected, no pulse).
  - btn_s=1 and cnt==DEBOUNCE_CYCLES-1 -> HELD. On this same edge: if en=1, t_out=1 and press_cnt+=1.
  - otherwise cnt+=1.
- HELD:
  - btn_s=0 -> DEB_RELEASE, cnt=0.
  - otherwise stay. No further pulses while held.
- DEB_RELEASE:
  - btn_s=1 -> HELD (release bounce, no pulse).
  - btn_s=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE.
  - otherwise cnt+=1.
- t_out is registered. It is high for exactly one cycle and low on the next edge unconditionally; two consecutive t_out cycles are impossible.
- Latency:
  - Take btn_in stable high from the sampling edge E0.
  - State becomes DEB_PRESS after E2.
  - t_out is high in the cycle following edge E(DEBOUNCE_CYCLES+2).
  - With the default value 4: t_out is high after the 7th sampling edge.
- en:
  - Sampled only on the accepting edge (DEB_PRESS->HELD).
  - If en=0 there, the press is consumed silently: no pulse, no count, and the FSM still goes to HELD.
  - en has no other effect.
- press_cnt: increments exactly when t_out is set and wraps from 2^CNT_W-1 to 0. It equals the number of accepted presses, and therefore the number of times the downstream flip-flop is commanded to toggle.
- busy: combinational decode of state != IDLE.
- DEBOUNCE_CYCLES=1: accept on the first edge in DEB_PRESS with btn_s=1, so the pulse comes 3 edges after E0.

Decomposition:
- Shared package toggle_pkg:
  - State encoding localparams (IDLE=2'd0, DEB_PRESS=2'd1, HELD=2'd2, DEB_RELEASE=2'd3).
  - Default DEBOUNCE_CYCLES.
- Sub-module sync_2ff: 1-bit two-flop synchroniser with asynchronous active-low reset to 0. Reusable for other asynchronous inputs.
- FSM, counter and output registers live in toggle_req_gen.

Test Plan:
- Reset: hold rst=0 with btn_in=1 for 3 cycles -> t_out=0, press_cnt=0, busy=0 throughout. Release rst with btn_in=1 held -> one t_out pulse after 7 edges, press_cnt=1.
- Clean press (DEBOUNCE_CYCLES=4, en=1): btn_in high for 20 cycles, then low for 20 -> exactly one 1-cycle t_out pulse on the 7th edge, press_cnt=1, busy low again 2+4 edges after btn_in falls.
- Glitch rejection: btn_in high for 3 cycles, then low -> no t_out, press_cnt=0, FSM returns to IDLE. Release bounce (low 2 cycles inside a 20-cycle hold) -> still a single pulse.
- Enable gating: en=0 on the accepting edge -> no t_out, press_cnt unchanged. A later press with en=1 -> pulse, press_cnt=1.
- Reset mid-operation: rst=0 asynchronously while in DEB_PRESS with cnt=2 -> outputs clear immediately (before the next clk edge), no pulse after release until a new full press.
- End-to-end with the toggle flip-flop: t_out drives the flip-flop's t input; 5 clean presses -> flip-flop q toggles 5 times (ends at 1 from 0), and press_cnt wrap checked with CNT_W=2 (4 presses -> press_cnt=0).
